// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control stage ahead of the ALU result multiplexer.
// It takes one request at a time and decodes the opcode into a one-hot
// mux command. The command and operands are held for ALU_LATENCY cycles,
// then the ALU result and flags are captured and offered downstream.
// Optional feature macro: ALU_SEQ_PERF_EN adds saturating counters
// op_count and err_count, which count legal and illegal completions.
module alu_op_sequencer #(
    parameter int ALU_LATENCY = 1,   // legal 1..15
    parameter int OP_W        = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] opcode,
    input  logic [31:0]     data_a,
    input  logic [31:0]     data_b,
    input  logic [4:0]      shamt,
    output logic [5:0]      command,
    output logic [31:0]     operand_a,
    output logic [31:0]     operand_b,
    output logic [4:0]      alu_shamt,
    input  logic [31:0]     alu_result,
    input  logic            alu_ovf,
    input  logic            alu_lt,
    input  logic            alu_ne,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     result,
    output logic            overflow,
    output logic            less_than,
    output logic            not_equal,
    output logic            op_error
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]     op_count,
    output logic [7:0]      err_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Opcode to one-hot mux select; opcodes 6 and 7 decode to all-zero (illegal)
    function automatic logic [5:0] f_decode(input logic [OP_W-1:0] op);
        logic [5:0] cmd;
        cmd = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            if (32'(op) == 32'(i)) begin
                cmd[i] = 1'b1;
            end
        end
        return cmd;
    endfunction

    state_t        r_state;
    logic [3:0]    r_hold;
    logic          r_in_ready;
    logic [5:0]    r_command;
    logic [31:0]   r_operand_a;
    logic [31:0]   r_operand_b;
    logic [4:0]    r_shamt;
    logic [31:0]   r_result;
    logic          r_ovf;
    logic          r_lt;
    logic          r_ne;
    logic          r_err;
    logic          r_out_valid;

    logic [5:0]    w_cmd;
    logic          w_legal;
    logic          w_accept;
    logic          w_done_hs;

    assign w_cmd     = f_decode(opcode);
    assign w_legal   = |w_cmd;
    assign w_accept  = in_valid && r_in_ready;
    assign w_done_hs = (r_state == S_DONE) && out_ready;

    // Sequencer FSM: accept, hold command for ALU_LATENCY cycles, capture, hand off
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_hold      <= 4'd0;
            r_in_ready  <= 1'b1;
            r_command   <= 6'b000000;
            r_operand_a <= 32'd0;
            r_operand_b <= 32'd0;
            r_shamt     <= 5'd0;
            r_result    <= 32'd0;
            r_ovf       <= 1'b0;
            r_lt        <= 1'b0;
            r_ne        <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_operand_a <= data_a;
                        r_operand_b <= data_b;
                        r_shamt     <= shamt;
                        r_in_ready  <= 1'b0;
                        if (w_legal) begin
                            r_state   <= S_ISSUE;
                            r_command <= w_cmd;
                            r_hold    <= 4'(ALU_LATENCY - 1);
                        end else begin
                            // Illegal op never reaches the ALU; report it straight away
                            r_state     <= S_DONE;
                            r_result    <= 32'd0;
                            r_ovf       <= 1'b0;
                            r_lt        <= 1'b0;
                            r_ne        <= 1'b0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_hold == 4'd0) begin
                        // Flags are only meaningful for the ops that use the adder
                        r_result    <= alu_result;
                        r_ovf       <= alu_ovf & (r_command[0] | r_command[1]);
                        r_lt        <= alu_lt & r_command[1];
                        r_ne        <= alu_ne & r_command[1];
                        r_err       <= 1'b0;
                        r_command   <= 6'b000000;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_hold <= r_hold - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_command  <= 6'b000000;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] f_sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    logic [15:0] r_op_count;
    logic [7:0]  r_err_count;

    // Completion counters, bumped on each downstream handshake
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_op_count  <= 16'd0;
            r_err_count <= 8'd0;
        end else if (w_done_hs) begin
            if (r_err) begin
                r_err_count <= f_sat_inc8(r_err_count);
            end else begin
                r_op_count <= f_sat_inc16(r_op_count);
            end
        end
    end

    assign op_count  = r_op_count;
    assign err_count = r_err_count;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_done_hs;
`endif

    assign in_ready  = r_in_ready;
    assign command   = r_command;
    assign operand_a = r_operand_a;
    assign operand_b = r_operand_b;
    assign alu_shamt = r_shamt;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign less_than = r_lt;
    assign not_equal = r_ne;
    assign op_error  = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LATENCY 1 and 3) share
// stimulus. Each instance has its own behavioural ALU model, and the
// vector table holds hand-computed expected results and flags.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [2:0]  opcode;
    logic [31:0] data_a, data_b;
    logic [4:0]  shamt;
    logic        out_ready;
    logic        m_ovf, m_lt, m_ne;

    logic        in_ready1, out_valid1, overflow1, lt1, ne1, err1;
    logic [5:0]  command1;
    logic [31:0] opa1, opb1, res_in1, result1;
    logic [4:0]  sh1;
    logic        in_ready3, out_valid3, overflow3, lt3, ne3, err3;
    logic [5:0]  command3;
    logic [31:0] opa3, opb3, res_in3, result3;
    logic [4:0]  sh3;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] op_count1, op_count3;
    logic [7:0]  err_count1, err_count3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_model(input logic [5:0] cmd, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        case (cmd)
            6'b000001: return a + b;
            6'b000010: return a - b;
            6'b000100: return a & b;
            6'b001000: return a | b;
            6'b010000: return a << sh;
            6'b100000: return $signed(a) >>> sh;
            default:   return 32'd0;
        endcase
    endfunction

    always_comb res_in1 = alu_model(command1, opa1, opb1, sh1);
    always_comb res_in3 = alu_model(command3, opa3, opb3, sh3);

    alu_op_sequencer #(.ALU_LATENCY(1), .OP_W(3)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .opcode(opcode), .data_a(data_a), .data_b(data_b), .shamt(shamt),
        .command(command1), .operand_a(opa1), .operand_b(opb1), .alu_shamt(sh1),
        .alu_result(res_in1), .alu_ovf(m_ovf), .alu_lt(m_lt), .alu_ne(m_ne),
        .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
        .overflow(overflow1), .less_than(lt1), .not_equal(ne1), .op_error(err1)
`ifdef ALU_SEQ_PERF_EN
        , .op_count(op_count1), .err_count(err_count1)
`endif
    );

    alu_op_sequencer #(.ALU_LATENCY(3), .OP_W(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready3),
        .opcode(opcode), .data_a(data_a), .data_b(data_b), .shamt(shamt),
        .command(command3), .operand_a(opa3), .operand_b(opb3), .alu_shamt(sh3),
        .alu_result(res_in3), .alu_ovf(m_ovf), .alu_lt(m_lt), .alu_ne(m_ne),
        .out_valid(out_valid3), .out_ready(out_ready), .result(result3),
        .overflow(overflow3), .less_than(lt3), .not_equal(ne3), .op_error(err3)
`ifdef ALU_SEQ_PERF_EN
        , .op_count(op_count3), .err_count(err_count3)
`endif
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        fo, fl, fn;       // flags the ALU model reports
        logic [31:0] exp_res;
        logic        exp_ovf, exp_lt, exp_ne, exp_err;
        logic [5:0]  exp_cmd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready1 && in_ready3) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!ok) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int          k3;
        int          c3cnt;
        int          c3bad;
        logic [31:0] r3;
        logic [3:0]  f3;
        string       p;
        p = $sformatf("v%0d_", idx);
        k3 = 0; c3cnt = 0; c3bad = 0; r3 = 32'hx; f3 = 4'hx;
        wait_idle();
        @(negedge clock);
        opcode = v.op; data_a = v.a; data_b = v.b; shamt = v.sh;
        m_ovf = v.fo; m_lt = v.fl; m_ne = v.fn;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
            end
            if (!v.exp_err) begin
                if (k == 1) begin
                    chk({p, "cmd"}, 32'(command1), 32'(v.exp_cmd));
                    chk({p, "ov_early"}, 32'(out_valid1), 32'd0);
                    chk({p, "opa"}, opa1, v.a);
                    chk({p, "opb"}, opb1, v.b);
                    chk({p, "sh"}, 32'(sh1), 32'(v.sh));
                end
                if (k == 2) begin
                    chk({p, "cmd_off"}, 32'(command1), 32'd0);
                    chk({p, "out_valid"}, 32'(out_valid1), 32'd1);
                    chk({p, "result"}, result1, v.exp_res);
                    chk({p, "flags"}, 32'({overflow1, lt1, ne1, err1}),
                        32'({v.exp_ovf, v.exp_lt, v.exp_ne, 1'b0}));
                    chk({p, "busy"}, 32'(in_ready1), 32'd0);
                end
                if (k == 3) begin
                    chk({p, "ready_back"}, 32'(in_ready1), 32'd1);
                    chk({p, "ov_clear"}, 32'(out_valid1), 32'd0);
                end
            end else begin
                if (k == 1) begin
                    chk({p, "err_cmd"}, 32'(command1), 32'd0);
                    chk({p, "err_valid"}, 32'(out_valid1), 32'd1);
                    chk({p, "err_result"}, result1, 32'd0);
                    chk({p, "err_flags"}, 32'({overflow1, lt1, ne1, err1}), 32'b0001);
                end
                if (k == 2) begin
                    chk({p, "err_ready_back"}, 32'(in_ready1), 32'd1);
                    chk({p, "err_clear"}, 32'({out_valid1, err1}), 32'd0);
                end
            end
            if (out_valid3 && k3 == 0) begin
                k3 = k;
                r3 = result3;
                f3 = {overflow3, lt3, ne3, err3};
            end
            if (command3 != 6'd0) begin
                c3cnt++;
                if (command3 != v.exp_cmd) c3bad++;
            end
        end
        chk({p, "lat3"}, 32'(k3), v.exp_err ? 32'd1 : 32'd4);
        chk({p, "result3"}, r3, v.exp_res);
        chk({p, "flags3"}, 32'(f3), 32'({v.exp_ovf, v.exp_lt, v.exp_ne, v.exp_err}));
        chk({p, "cmd3_cycles"}, 32'(c3cnt), v.exp_err ? 32'd0 : 32'd3);
        chk({p, "cmd3_value"}, 32'(c3bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0] = '{op:3'd0, a:32'd5,          b:32'd7,          sh:5'd0,  fo:1'b0, fl:1'b0, fn:1'b0,
                    exp_res:32'd12,         exp_ovf:1'b0, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b0, exp_cmd:6'b000001};
        vecs[1] = '{op:3'd1, a:32'd3,          b:32'd9,          sh:5'd0,  fo:1'b0, fl:1'b1, fn:1'b1,
                    exp_res:32'hFFFFFFFA,   exp_ovf:1'b0, exp_lt:1'b1, exp_ne:1'b1, exp_err:1'b0, exp_cmd:6'b000010};
        vecs[2] = '{op:3'd2, a:32'hF0F000FF,   b:32'h0FF00F0F,   sh:5'd0,  fo:1'b1, fl:1'b1, fn:1'b1,
                    exp_res:32'h00F0000F,   exp_ovf:1'b0, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b0, exp_cmd:6'b000100};
        vecs[3] = '{op:3'd3, a:32'h12340000,   b:32'h00005678,   sh:5'd0,  fo:1'b1, fl:1'b0, fn:1'b1,
                    exp_res:32'h12345678,   exp_ovf:1'b0, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b0, exp_cmd:6'b001000};
        vecs[4] = '{op:3'd7, a:32'hDEADBEEF,   b:32'h1,          sh:5'd3,  fo:1'b1, fl:1'b1, fn:1'b1,
                    exp_res:32'd0,          exp_ovf:1'b0, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b1, exp_cmd:6'b000000};
        vecs[5] = '{op:3'd0, a:32'h7FFFFFFF,   b:32'd1,          sh:5'd0,  fo:1'b1, fl:1'b1, fn:1'b1,
                    exp_res:32'h80000000,   exp_ovf:1'b1, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b0, exp_cmd:6'b000001};
        vecs[6] = '{op:3'd4, a:32'd1,          b:32'd0,          sh:5'd31, fo:1'b0, fl:1'b0, fn:1'b0,
                    exp_res:32'h80000000,   exp_ovf:1'b0, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b0, exp_cmd:6'b010000};
        vecs[7] = '{op:3'd5, a:32'h80000000,   b:32'd0,          sh:5'd4,  fo:1'b0, fl:1'b0, fn:1'b0,
                    exp_res:32'hF8000000,   exp_ovf:1'b0, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b0, exp_cmd:6'b100000};
        vecs[8] = '{op:3'd6, a:32'h0,          b:32'h0,          sh:5'd0,  fo:1'b0, fl:1'b0, fn:1'b0,
                    exp_res:32'd0,          exp_ovf:1'b0, exp_lt:1'b0, exp_ne:1'b0, exp_err:1'b1, exp_cmd:6'b000000};
        vecs[9] = '{op:3'd1, a:32'h80000000,   b:32'd1,          sh:5'd0,  fo:1'b1, fl:1'b1, fn:1'b1,
                    exp_res:32'h7FFFFFFF,   exp_ovf:1'b1, exp_lt:1'b1, exp_ne:1'b1, exp_err:1'b0, exp_cmd:6'b000010};

        reset_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; data_a = 32'd0; data_b = 32'd0;
        shamt = 5'd0; out_ready = 1'b1; m_ovf = 1'b0; m_lt = 1'b0; m_ne = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready1", 32'(in_ready1), 32'd1);
        chk("rst_ready3", 32'(in_ready3), 32'd1);
        chk("rst_cmd", 32'({command1, command3}), 32'd0);
        chk("rst_operands", opa1 | opb1 | 32'(sh1) | opa3 | opb3 | 32'(sh3), 32'd0);
        chk("rst_result", result1 | result3, 32'd0);
        chk("rst_status", 32'({out_valid1, overflow1, lt1, ne1, err1,
                               out_valid3, overflow3, lt3, ne3, err3}), 32'd0);
`ifdef ALU_SEQ_PERF_EN
        chk("rst_perf", 32'(op_count1) | 32'(err_count1) | 32'(op_count3) | 32'(err_count3), 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 10; i++) begin
            apply_vec(i, vecs[i]);
        end

        // Back-pressure on the 3-cycle instance: SRA held in DONE by out_ready low
        wait_idle();
        @(negedge clock);
        out_ready = 1'b0;
        opcode = 3'd5; data_a = 32'h80000000; data_b = 32'd0; shamt = 5'd4;
        m_ovf = 1'b0; m_lt = 1'b0; m_ne = 1'b0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
            end
            chk($sformatf("bp_cmd_k%0d", k), 32'(command3), (k <= 3) ? 32'h20 : 32'd0);
            chk($sformatf("bp_valid_k%0d", k), 32'(out_valid3), (k <= 3) ? 32'd0 : 32'd1);
        end
        for (int j = 0; j < 5; j++) begin
            @(posedge clock); #1;
            chk($sformatf("bp_hold_valid%0d", j), 32'(out_valid3), 32'd1);
            chk($sformatf("bp_hold_result%0d", j), result3, 32'hF8000000);
            chk($sformatf("bp_hold_busy%0d", j), 32'({in_ready3, in_ready1}), 32'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_ready_after", 32'(in_ready3), 32'd1);
        chk("bp_valid_after", 32'(out_valid3), 32'd0);
        chk("bp_result_kept", result3, 32'hF8000000);

        // Reset asserted while both instances are in ISSUE
        wait_idle();
        @(negedge clock);
        opcode = 3'd0; data_a = 32'd5; data_b = 32'd7; shamt = 5'd0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("abort_in_issue", 32'(command3), 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("abort_idle", 32'({in_ready3, in_ready1}), 32'b11);
        chk("abort_cmd", 32'({command3, command1}), 32'd0);
        chk("abort_valid", 32'({out_valid3, out_valid1}), 32'd0);
        chk("abort_result", result3, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clock); #1;
            if (out_valid1 || out_valid3) cnt++;
        end
        chk("abort_no_output", 32'(cnt), 32'd0);

`ifdef ALU_SEQ_PERF_EN
        apply_vec(20, vecs[0]);
        apply_vec(21, vecs[1]);
        apply_vec(22, vecs[2]);
        apply_vec(23, vecs[4]);
        chk("perf_op1", 32'(op_count1), 32'd3);
        chk("perf_err1", 32'(err_count1), 32'd1);
        chk("perf_op3", 32'(op_count3), 32'd3);
        chk("perf_err3", 32'(err_count3), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control stage directly upstream of the ALU result multiplexer.
- Accepts one operation request at a time over a valid/ready handshake and decodes the binary opcode into the 6-bit one-hot command that drives the result mux.
- Registers the operands and holds the command stable for a configurable number of cycles, then captures the ALU result and flags.
- Presents the captured result downstream over a second valid/ready handshake.

Parameters:
ALU_LATENCY, 1, cycles the command/operands are held before the result is sampled; legal 1..15
OP_W, 3, opcode width

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  sequencer can accept a request
opcode  input  OP_W  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra; 6,7 illegal
data_a  input  32  operand A
data_b  input  32  operand B
shamt  input  5  shift amount
command  output  6  one-hot mux select to ALU datapath
operand_a  output  32  registered operand A to ALU
operand_b  output  32  registered operand B to ALU
alu_shamt  output  5  registered shift amount to ALU
alu_result  input  32  selected ALU result (mux output)
alu_ovf  input  1  ALU overflow
alu_lt  input  1  A<B from subtractor
alu_ne  input  1  A!=B from subtractor
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  32  captured result
overflow  output  1  captured overflow; add/sub only, else 0
less_than  output  1  captured alu_lt; sub only, else 0
not_equal  output  1  captured alu_ne; sub only, else 0
op_error  output  1  request carried an illegal opcode

Behaviour:
- FSM states: IDLE, ISSUE, DONE.
- Reset (reset_n=0 at a rising edge): state IDLE; in_ready=1; command=6'b000000; operand_a, operand_b, alu_shamt, result=0; out_valid, overflow, less_than, not_equal, op_error=0; hold counter=0.
- Reset mid-operation: any in-flight op is discarded; no out_valid is produced for it.
- in_ready=1 only in IDLE.
- Accept = in_valid && in_ready, sampled at edge T.
- Legal opcode accepted: operands latched at T; state ISSUE from T+1.
  - command = 1<<opcode throughout ISSUE, 6'b000000 in every other state.
  - ISSUE lasts exactly ALU_LATENCY cycles, counted by an internal down-counter.
  - On the last ISSUE edge, capture alu_result into result and capture the flags (masked per opcode); enter DONE.
- Illegal opcode (6,7) accepted: skip ISSUE; enter DONE at T with result=0, op_error=1, all flags 0; command stays 0.
- DONE: out_valid=1; result, flags and op_error held stable until out_valid && out_ready.
  - On that edge: return to IDLE; out_valid=0; op_error cleared.
  - result and flags keep their last value.
- Latency with ALU_LATENCY=1 and out_ready held 1: accept at T, command valid during T+1, out_valid during T+2, in_ready again at T+3.
- Throughput: one op per ALU_LATENCY+2 cycles.
- Back-pressure: out_ready low holds DONE indefinitely; in_ready stays 0.
- in_valid while busy is ignored; the requester must hold it until accepted.
- operand_a, operand_b and alu_shamt hold the last accepted values while idle.
- Operands are not sign-extended or truncated; 32-bit pass-through.

Optional Feature:
ALU_SEQ_PERF_EN
- Defined: adds outputs op_count[15:0] and err_count[7:0], both reset to 0.
  - op_count increments on each DONE handshake of a legal op.
  - err_count increments on each DONE handshake of an illegal op.
  - Both saturate at all-ones.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then ADD, ALU_LATENCY=1, A=5, B=7, ALU model returns 12:
  - command=6'b000001 during exactly one cycle;
  - out_valid two cycles after accept, result=12, overflow=0.
- SUB, A=3, B=9, model alu_lt=1, alu_ne=1, alu_ovf=0 -> command=6'b000010, result=32'hFFFFFFFA, less_than=1, not_equal=1.
- AND with model alu_ovf=1, alu_lt=1 -> overflow=0, less_than=0 (masked); command=6'b000100.
- opcode=7 -> out_valid the cycle after accept, op_error=1, result=0, command never nonzero; next op clears op_error.
- ALU_LATENCY=3, SRA, shamt=4, out_ready low 5 cycles:
  - command=6'b100000 for exactly 3 cycles;
  - result stable and in_ready=0 until out_ready rises;
  - in_ready=1 the cycle after the handshake.
- Assert reset_n=0 during ISSUE -> next cycle in IDLE with command=0 and out_valid=0; no result emitted for the aborted op.
  - With ALU_SEQ_PERF_EN: 3 legal ops + 1 illegal op -> op_count=3, err_count=1.
